// File: rtl/muldiv_iter_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
// Latency: none, wires only.
// Backpressure: requester watches busy; start while busy is dropped by the slave.
interface muldiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src1, src2, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src1, src2, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU engine: radix-2 shift/add multiply, restoring divide.
// Latency: WIDTH+1 cycles from start edge to done pulse; one result per WIDTH+2 back-to-back.
// Backpressure: busy high while computing; start is ignored (not queued) while busy, cancel aborts.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        reset,
  muldiv_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_res;   // operand signs differ: product / quotient negated
  logic               neg_rem;   // dividend negative: remainder negated
  logic               div_zero;
  logic [WIDTH-1:0]   opa;       // multiplicand magnitude
  logic [WIDTH-1:0]   opb;       // multiplier or divisor magnitude
  logic [WIDTH-1:0]   src1_raw;  // dividend as supplied, returned on divide by zero
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] acc;       // mult: {partial sum, multiplier}; div: low half is dividend/quotient
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               signed_op;
  logic               s1_neg;
  logic               s2_neg;
  logic [WIDTH-1:0]   s1_mag;
  logic [WIDTH-1:0]   s2_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;

  // Operand magnitudes and per-iteration datapath
  always_comb begin
    signed_op = ~bus.op[0];
    s1_neg    = signed_op & bus.src1[WIDTH-1];
    s2_neg    = signed_op & bus.src2[WIDTH-1];
    s1_mag    = s1_neg ? ({WIDTH{1'b0}} - bus.src1) : bus.src1;
    s2_mag    = s2_neg ? ({WIDTH{1'b0}} - bus.src2) : bus.src2;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});
    rem_shift = {rem, acc[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, opb};
  end

  // Control FSM with datapath registers and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      src1_raw <= '0;
      rem      <= '0;
      acc      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (bus.cancel) begin
      // Flush wins over everything, including a same-cycle start; results untouched
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state    <= CALC;
            busy_q   <= 1'b1;
            cnt      <= '0;
            is_div   <= bus.op[1];
            neg_res  <= s1_neg ^ s2_neg;
            neg_rem  <= s1_neg;
            div_zero <= bus.op[1] && (bus.src2 == '0);
            opa      <= s1_mag;
            opb      <= bus.op[1] ? s2_mag : s1_mag;
            src1_raw <= bus.src1;
            rem      <= '0;
            acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? s1_mag : s2_mag)};
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], rem_ge};
            rem <= rem_ge ? WIDTH'(rem_shift - {1'b0, opb}) : rem_shift[WIDTH-1:0];
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            if (div_zero) begin
              lo_q <= {WIDTH{1'b1}};
              hi_q <= src1_raw;
            end else begin
              lo_q <= neg_res ? ({WIDTH{1'b0}} - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
              hi_q <= neg_rem ? ({WIDTH{1'b0}} - rem) : rem;
            end
          end else begin
            {hi_q, lo_q} <= neg_res ? ({(2*WIDTH){1'b0}} - acc) : acc;
          end
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed and randomized checks of muldiv_iter against an arithmetic reference model.
// Latency: checks WIDTH+1 start-to-done and WIDTH+2 back-to-back spacing.
// Backpressure: exercises start-while-busy, cancel and asynchronous reset.
module tb_muldiv_iter;
  localparam int W = 32;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] last_exp;

  muldiv_iter_if #(.WIDTH(W)) bus ();

  muldiv_iter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {hi, lo} straight from the instruction definitions
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    int     qa, qb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin p = sa * sb; r = p; end
      2'd1: r = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin
          qa = $signed(a);
          qb = $signed(b);
          r = {32'(qa % qb), 32'(qa / qb)};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from idle; returns in the done cycle (sampled just after its edge)
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit spam, input string tag);
    int n;
    int busy_n;
    logic [63:0] exp;
    exp = model(o, a, b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.src1  = a;
    bus.src2  = b;
    step();                 // E0 accepted
    bus.start = 1'b0;
    n = 0;
    busy_n = bus.busy ? 1 : 0;
    while (!bus.done && n < 100) begin
      if (spam && bus.busy) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.op    = 2'($urandom_range(0, 3));
        bus.src1  = $urandom;
        bus.src2  = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      step();
      n++;
      if (bus.busy) busy_n++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 64'(n), 64'(W + 1));
    check({tag, " busy_cycles"}, 64'(busy_n), 64'(W + 1));
    check({tag, " hi"}, {32'd0, bus.hi}, {32'd0, exp[63:32]});
    check({tag, " lo"}, {32'd0, bus.lo}, {32'd0, exp[31:0]});
    last_exp = exp;
  endtask

  initial begin
    int n;
    int dones;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.src1  = '0;
    bus.src2  = '0;
    bus.cancel = 1'b0;
    last_exp  = '0;
    #23;
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset done", {63'd0, bus.done}, 64'd0);
    check("reset hilo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b1;
    step();
    step();

    // Directed cases
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    step();
    do_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_m3x7");
    do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minxmin");
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7d2");
    do_op(2'd3, 32'd7, 32'd2, 1'b0, "divu_7d2");
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    do_op(2'd3, 32'd5, 32'd0, 1'b0, "divu_by0");
    do_op(2'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, "div_by0_neg");
    step();

    // Start pulses while busy must not create extra results
    do_op(2'd3, 32'd1000, 32'd7, 1'b1, "spam");
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done) dones++;
    end
    check("spam extra_done", 64'(dones), 64'd0);

    // Cancel mid-divide
    bus.start = 1'b1; bus.op = 2'd3; bus.src1 = 32'd100; bus.src2 = 32'd3;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    check("cancel busy", {63'd0, bus.busy}, 64'd0);
    check("cancel done", {63'd0, bus.done}, 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done) dones++;
    end
    check("cancel no_done", 64'(dones), 64'd0);
    check("cancel hilo", {bus.hi, bus.lo}, last_exp);

    // Cancel wins over a simultaneous start
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 2'd1; bus.src1 = 32'd3; bus.src2 = 32'd3;
    step();
    bus.start = 1'b0; bus.cancel = 1'b0;
    check("cancel_vs_start busy", {63'd0, bus.busy}, 64'd0);

    // Randomized ops against the model
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: ra = ra & 32'hFF;
        2: rb = rb & 32'hF;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      do_op(ro, ra, rb, 1'b0, "random");
    end

    // Asynchronous reset in the middle of a MULT
    bus.start = 1'b1; bus.op = 2'd0; bus.src1 = 32'h1234_5678; bus.src2 = 32'hFFFF_0001;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    #2;
    reset = 1'b0;
    #1;
    check("arst busy", {63'd0, bus.busy}, 64'd0);
    check("arst done", {63'd0, bus.done}, 64'd0);
    check("arst hilo", {bus.hi, bus.lo}, 64'd0);
    step();
    step();
    #3;
    reset = 1'b1;
    step();

    // Back-to-back: second start issued in the first op's done cycle
    do_op(2'd1, 32'd2, 32'd3, 1'b0, "b2b_first");
    bus.start = 1'b1; bus.op = 2'd3; bus.src1 = 32'd9; bus.src2 = 32'd4;
    step();
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 100) begin
      step();
      n++;
    end
    check("b2b spacing", 64'(n), 64'(W + 2));
    check("b2b lo", {32'd0, bus.lo}, 64'd2);
    check("b2b hi", {32'd0, bus.hi}, 64'd1);
    step();
    check("b2b done_pulse", {63'd0, bus.done}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised iterative multiply/divide unit producing HI/LO results for the MULT, MULTU, DIV and DIVU instructions. It sits beside the EX-stage ALU and replaces the single-cycle high-result path with a WIDTH-cycle shift/add and restoring-divide engine. A start/busy/done handshake lets the pipeline stall on busy, and a cancel input lets a flush kill an in-flight operation.

## Interface
- WIDTH, 32: operand width; products are 2*WIDTH bits; must be ≥ 4.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately when low.
- start  in  1  request; sampled only when busy=0.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start.
- src1  in  WIDTH  multiplicand or dividend (rs data).
- src2  in  WIDTH  multiplier or divisor (rt data).
- cancel  in  1  synchronous abort of any operation in progress.
- busy  out  1  high in CALC and FIX states.
- done  out  1  one-cycle pulse; hi/lo are valid and newly updated in that cycle.
- hi  out  WIDTH  upper product or remainder; holds its value until the next completion.
- lo  out  WIDTH  lower product or quotient; holds its value until the next completion.

## Operation
- States: IDLE, CALC, FIX, DONE. busy=1 in CALC and FIX. done=1 only in DONE.
- IDLE or DONE, start=1, cancel=0: latch op, sign flags and operand magnitudes. Signed ops use the two's-complement absolute value; unsigned ops use operands as-is. Clear the iteration counter. Go to CALC.
- CALC: one iteration per cycle, counter 0..WIDTH-1. Go to FIX on the edge where the counter equals WIDTH-1.
  - Multiply: radix-2 shift/add into a 2*WIDTH-bit accumulator.
  - Divide: restoring division with a WIDTH+1-bit partial remainder.
- FIX: apply signs and register hi/lo, then go to DONE.
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: quotient is negative if the signs differ; remainder takes the sign of the dividend.
- DONE: go to IDLE next edge, or to CALC if a new start is accepted.
- Start while busy=1 is ignored and is not queued.
- cancel=1: next edge goes to IDLE. No done pulse. hi/lo are unchanged. cancel overrides a simultaneous start.
- Divide by zero: the operation runs for the full latency and yields lo={WIDTH{1}}, hi=src1 as supplied. The sign fix is suppressed.
- Signed overflow (most negative value / -1): lo=most negative value, hi=0. This is the natural result of the magnitude datapath.
- reset low: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, operand registers=0, asynchronously.

## Timing
- Start is accepted on edge E0. CALC occupies edges E1..E(WIDTH). FIX writes hi/lo on edge E(WIDTH+1).
- done is high for exactly one cycle, between E(WIDTH+1) and E(WIDTH+2). Latency is WIDTH+1 cycles (33 for WIDTH=32).
- busy rises on E0 and falls on E(WIDTH+1).
- Back-to-back: a start in the DONE cycle is accepted, giving one result every WIDTH+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF (WIDTH=32):
  - hi=0xFFFFFFFE, lo=0x00000001.
  - done exactly 33 cycles after the start edge; busy high for 33 cycles.
- MULT -3 × 7: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULT 0x80000000 × 0x80000000: hi=0x40000000, lo=0.
- DIV -7 / 2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 7 / 2: lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU 5 / 0: lo=0xFFFFFFFF, hi=5, after the full 33-cycle latency.
- Cancel:
  - Start DIVU 100/3, assert cancel on cycle 10: busy=0 after the next edge, no done pulse, hi/lo keep their prior values.
  - start pulses during busy produce no extra done.
- Reset mid-operation, then back-to-back:
  - Drop reset at cycle 15 of a MULT: busy, done, hi and lo go to 0 without waiting for a clock.
  - After release, a MULTU 2×3 followed by a start in its DONE cycle (DIVU 9/4) gives lo=6, then lo=2 with hi=1, the done pulses 34 cycles apart.
